survivor_mem: RTL and testbench

- Survivor-path memory between the add-compare-select (ACS) unit and the traceback stage of the Viterbi decoder.
- Buffers one frame of per-state back-pointer columns from ACS, then selects the minimum-metric final state.
- Replays the stored columns newest-first while driving traceback's enable, select-node and previous-state inputs.
- Waits for traceback's done flag, then accepts the next frame.

---
 rtl/viterbi_pkg.sv | 37 +++
 rtl/survivor_mem_if.sv | 25 ++
 rtl/survivor_mem_min_metric_sel.sv | 24 ++
 rtl/survivor_mem.sv | 83 ++++++++
 tb/tb_survivor_mem.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants and types. Sizes follow the legacy param_def
// macros when they are defined, otherwise the default 4-state configuration.
`ifndef MAX_STATE_NUM
`define MAX_STATE_NUM 4
`endif
`ifndef MAX_STATE_REG_NUM
`define MAX_STATE_REG_NUM 2
`endif
`ifndef TRACEBACK_DEPTH
`define TRACEBACK_DEPTH 5
`endif

package viterbi_pkg;

  localparam int NUM_STATES = `MAX_STATE_NUM;
  localparam int ST_W       = `MAX_STATE_REG_NUM;
  localparam int TB_DEPTH   = `TRACEBACK_DEPTH;

  localparam int PM_W  = 8;
  // One spare code above TB_DEPTH-1 so the write counter may sit past the last column.
  localparam int PTR_W = $clog2(TB_DEPTH + 1);

  typedef logic [ST_W-1:0]  state_t;
  typedef logic [PM_W-1:0]  metric_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef state_t  [NUM_STATES-1:0] col_t;
  typedef metric_t [NUM_STATES-1:0] metric_vec_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SELECT = 2'd1,
    TRACE  = 2'd2,
    DONE   = 2'd3
  } sm_state_e;

endpackage

// File: rtl/survivor_mem_if.sv
// ACS-side and traceback-side signals of the survivor memory. The signal names
// keep the legacy port names.
interface survivor_mem_if;
  import viterbi_pkg::*;

  logic        i_acs_valid;
  col_t        i_prv_st;
  metric_vec_t i_path_metric;
  logic        i_tb_done;
  logic        o_ready;
  logic        o_en_t;
  state_t      o_sel_node;
  col_t        o_bck_prv_st;
  logic        o_frame_done;

  modport master (
    output i_acs_valid, i_prv_st, i_path_metric, i_tb_done,
    input  o_ready, o_en_t, o_sel_node, o_bck_prv_st, o_frame_done
  );

  modport slave (
    input  i_acs_valid, i_prv_st, i_path_metric, i_tb_done,
    output o_ready, o_en_t, o_sel_node, o_bck_prv_st, o_frame_done
  );
endinterface

// File: rtl/survivor_mem_min_metric_sel.sv
// Combinational argmin over the per-state path metrics (unsigned, full width);
// a tie resolves to the lowest state index.
module min_metric_sel
  import viterbi_pkg::*;
(
  input  metric_vec_t i_metric,
  output state_t      o_idx
);

  metric_t w_best;

  always_comb begin
    w_best = i_metric[0];
    o_idx  = '0;
    // Strict less-than keeps the earlier index when metrics are equal.
    for (int unsigned i = 1; i < NUM_STATES; i++) begin
      if (i_metric[i] < w_best) begin
        w_best = i_metric[i];
        o_idx  = state_t'(i);
      end
    end
  end

endmodule

// File: rtl/survivor_mem.sv
// Survivor-path memory: buffers one frame of ACS back-pointer columns, picks the
// best final state, then replays the columns newest-first into traceback.
module survivor_mem
  import viterbi_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  survivor_mem_if.slave  bus
);

  sm_state_e r_state;
  ptr_t      r_wr_cnt;
  ptr_t      r_rd_ptr;
  state_t    r_sel_node;
  col_t      r_mem [TB_DEPTH];

  state_t    w_min_idx;
  logic      w_wr;
  logic      w_last_wr;

  min_metric_sel u_min_metric_sel (
    .i_metric (bus.i_path_metric),
    .o_idx    (w_min_idx)
  );

  assign w_wr      = (r_state == FILL) && bus.i_acs_valid;
  assign w_last_wr = w_wr && (r_wr_cnt == ptr_t'(TB_DEPTH - 1));

  // Column storage has no reset; stale contents are never presented.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_cnt] <= bus.i_prv_st;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= FILL;
      r_wr_cnt   <= '0;
      r_rd_ptr   <= '0;
      r_sel_node <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_wr) begin
            r_wr_cnt <= r_wr_cnt + ptr_t'(1);
          end
          if (w_last_wr) begin
            r_sel_node <= w_min_idx;
            r_rd_ptr   <= ptr_t'(TB_DEPTH - 1);
            r_state    <= SELECT;
          end
        end
        SELECT: begin
          r_state <= TRACE;
        end
        TRACE: begin
          // Column 0 repeats once the pointer bottoms out.
          if (r_rd_ptr != '0) begin
            r_rd_ptr <= r_rd_ptr - ptr_t'(1);
          end
          if (bus.i_tb_done) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_wr_cnt <= '0;
          r_state  <= FILL;
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign bus.o_ready      = (r_state == FILL);
  assign bus.o_en_t       = (r_state == TRACE);
  assign bus.o_frame_done = (r_state == DONE);
  assign bus.o_sel_node   = r_sel_node;
  assign bus.o_bck_prv_st = (r_state == TRACE) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_survivor_mem.sv
// Self-checking bench for survivor_mem: frames are built from random or directed
// columns and compared against an argmin / newest-first replay reference.
module tb_survivor_mem;
  import viterbi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  survivor_mem_if bus ();

  survivor_mem u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  col_t        m_cols [TB_DEPTH];
  metric_vec_t m_last;

  // Smallest metric value first, then the lowest index holding it.
  function automatic state_t ref_argmin(input metric_vec_t m);
    int lo;
    int idx;
    lo  = 32'h7fff_ffff;
    idx = 0;
    for (int i = 0; i < NUM_STATES; i++)
      if (int'(m[i]) < lo) lo = int'(m[i]);
    for (int i = NUM_STATES - 1; i >= 0; i--)
      if (int'(m[i]) == lo) idx = i;
    return state_t'(idx);
  endfunction

  // Trace cycle t shows column TB_DEPTH-1-t, clamped at column 0.
  function automatic int ref_col_idx(input int t);
    return (TB_DEPTH - 1 - t < 0) ? 0 : TB_DEPTH - 1 - t;
  endfunction

  task automatic randomize_frame();
    for (int k = 0; k < TB_DEPTH; k++) m_cols[k] = col_t'($urandom);
    m_last = metric_vec_t'($urandom);
    if ($urandom_range(1, 0) == 1) m_last[$urandom_range(NUM_STATES - 1, 1)] = m_last[0];
  endtask

  task automatic drive_side(input bit hold, input bit noise);
    bus.i_acs_valid   = hold;
    bus.i_prv_st      = col_t'($urandom);
    bus.i_path_metric = metric_vec_t'($urandom);
    bus.i_tb_done     = noise && ($urandom_range(1, 0) == 1);
  endtask

  // Drives the frame's columns; returns at the negedge of the SELECT cycle.
  task automatic fill_frame(input int max_gap, input bit noise);
    for (int k = 0; k < TB_DEPTH; k++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        drive_side(1'b0, noise);
        @(negedge clk);
      end
      bus.i_acs_valid   = 1'b1;
      bus.i_prv_st      = m_cols[k];
      bus.i_path_metric = (k == TB_DEPTH - 1) ? m_last : metric_vec_t'($urandom);
      bus.i_tb_done     = noise && ($urandom_range(1, 0) == 1);
      @(negedge clk);
    end
    bus.i_acs_valid = 1'b0;
    bus.i_tb_done   = 1'b0;
  endtask

  task automatic do_frame(input string tag, input int max_gap, input int trace_len,
                          input bit hold, input bit noise);
    state_t exp_sel;
    exp_sel = ref_argmin(m_last);
    fill_frame(max_gap, noise);
    total++;
    if (bus.o_ready !== 1'b0 || bus.o_en_t !== 1'b0 || bus.o_frame_done !== 1'b0) begin
      bad++;
      $display("FAIL %s_select_ctl got rdy=%b en=%b fd=%b want 0/0/0", tag,
               bus.o_ready, bus.o_en_t, bus.o_frame_done);
    end
    total++;
    if (bus.o_sel_node !== exp_sel) begin
      bad++;
      $display("FAIL %s_sel_node got=%0d want=%0d", tag, bus.o_sel_node, exp_sel);
    end
    drive_side(hold, noise);
    @(negedge clk);
    for (int t = 0; t < trace_len; t++) begin
      total++;
      if (bus.o_en_t !== 1'b1 || bus.o_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s_trace_ctl t=%0d got en=%b rdy=%b want 1/0", tag, t,
                 bus.o_en_t, bus.o_ready);
      end
      total++;
      if (bus.o_bck_prv_st !== m_cols[ref_col_idx(t)]) begin
        bad++;
        $display("FAIL %s_trace_col t=%0d got=%h want=%h", tag, t,
                 bus.o_bck_prv_st, m_cols[ref_col_idx(t)]);
      end
      drive_side(hold, 1'b0);
      bus.i_tb_done = (t == trace_len - 1);
      @(negedge clk);
    end
    drive_side(hold, noise);
    total++;
    if (bus.o_en_t !== 1'b0 || bus.o_frame_done !== 1'b1 || bus.o_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_ctl got en=%b fd=%b rdy=%b want 0/1/0", tag,
               bus.o_en_t, bus.o_frame_done, bus.o_ready);
    end
    drive_side(1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (bus.o_frame_done !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_en_t !== 1'b0) begin
      bad++;
      $display("FAIL %s_refill_ctl got fd=%b rdy=%b en=%b want 0/1/0", tag,
               bus.o_frame_done, bus.o_ready, bus.o_en_t);
    end
    total++;
    if (bus.o_sel_node !== exp_sel) begin
      bad++;
      $display("FAIL %s_sel_hold got=%0d want=%0d", tag, bus.o_sel_node, exp_sel);
    end
  endtask

  task automatic test_reset();
    drive_side(1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.o_ready !== 1'b1 || bus.o_en_t !== 1'b0 || bus.o_frame_done !== 1'b0 ||
        bus.o_sel_node !== state_t'(0) || bus.o_bck_prv_st !== col_t'(0)) begin
      bad++;
      $display("FAIL reset_state got rdy=%b en=%b fd=%b sel=%0d bck=%h want 1/0/0/0/0",
               bus.o_ready, bus.o_en_t, bus.o_frame_done, bus.o_sel_node, bus.o_bck_prv_st);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_basic();
    for (int k = 0; k < TB_DEPTH; k++)
      for (int s = 0; s < NUM_STATES; s++) m_cols[k][s] = state_t'(k % 4);
    m_last[0] = 8'd9;
    m_last[1] = 8'd3;
    m_last[2] = 8'd7;
    m_last[3] = 8'd5;
  endtask

  task automatic test_basic();
    set_basic();
    do_frame("basic", 0, TB_DEPTH, 1'b0, 1'b0);
  endtask

  task automatic test_tiebreak();
    randomize_frame();
    m_last[0] = 8'd4;
    m_last[1] = 8'd2;
    m_last[2] = 8'd2;
    m_last[3] = 8'd8;
    do_frame("tie_4228", 0, TB_DEPTH, 1'b0, 1'b0);
    randomize_frame();
    m_last = '0;
    do_frame("tie_zero", 0, TB_DEPTH, 1'b0, 1'b0);
    randomize_frame();
    m_last = '1;
    m_last[NUM_STATES - 1] = 8'd254;
    do_frame("top_state", 0, TB_DEPTH, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    randomize_frame();
    do_frame("overrun", 0, 8, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    randomize_frame();
    do_frame("backpr", 0, TB_DEPTH, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      total++;
      if (bus.o_ready !== 1'b1 || bus.o_en_t !== 1'b0) begin
        bad++;
        $display("FAIL backpr_idle got rdy=%b en=%b want 1/0", bus.o_ready, bus.o_en_t);
      end
    end
    randomize_frame();
    do_frame("backpr_next", 0, TB_DEPTH, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_trace();
    randomize_frame();
    m_last[0] = 8'd255;
    m_last[1] = 8'd0;
    fill_frame(0, 1'b0);
    @(negedge clk);
    total++;
    if (bus.o_bck_prv_st !== m_cols[TB_DEPTH - 1] || bus.o_en_t !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_first got bck=%h en=%b want %h/1", bus.o_bck_prv_st,
               bus.o_en_t, m_cols[TB_DEPTH - 1]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.o_en_t !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_sel_node !== state_t'(0) ||
        bus.o_frame_done !== 1'b0 || bus.o_bck_prv_st !== col_t'(0)) begin
      bad++;
      $display("FAIL rstmid_state got en=%b rdy=%b sel=%0d fd=%b bck=%h want 0/1/0/0/0",
               bus.o_en_t, bus.o_ready, bus.o_sel_node, bus.o_frame_done, bus.o_bck_prv_st);
    end
    rst = 1'b1;
    @(negedge clk);
    randomize_frame();
    do_frame("rstmid_fresh", 0, TB_DEPTH, 1'b0, 1'b0);
  endtask

  task automatic test_gapped();
    set_basic();
    do_frame("gapped_a", 3, TB_DEPTH, 1'b0, 1'b0);
    do_frame("gapped_b", 3, TB_DEPTH, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      randomize_frame();
      do_frame("random", int'($urandom_range(3, 0)), int'($urandom_range(9, 1)),
               ($urandom_range(1, 0) == 1), 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_tiebreak();
    test_overrun();
    test_backpressure();
    test_reset_mid_trace();
    test_gapped();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
